// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
// Shared definitions for the multdiv functional-unit cluster:
//   - state_t     : common IDLE / SHIFT / DONE handshake states
//   - NUM_STAGES  : number of binary-weighted right-shift stages (16,8,4,2,1)
//   - stage_weight: maps a stage index k to its shift weight (16 >> k)
// -----------------------------------------------------------------------------
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_STAGES = 5;

    function automatic logic [4:0] stage_weight(input logic [2:0] k);
        return 5'd16 >> k;
    endfunction

endpackage

// File: rtl/shr_stage.sv
// -----------------------------------------------------------------------------
// shr_stage
// One combinational right-shift stage with fill replication.
// Ports:
//   i_in     [WIDTH-1:0] value entering the stage
//   i_fill               bit replicated into the vacated MSBs
//   i_en                 1 = apply the shift, 0 = pass i_in through
//   i_weight [4:0]       shift distance for this stage (16, 8, 4, 2 or 1)
//   o_out    [WIDTH-1:0] stage result
// -----------------------------------------------------------------------------
module shr_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_fill,
    input  logic             i_en,
    input  logic [4:0]       i_weight,
    output logic [WIDTH-1:0] o_out
);

    logic [WIDTH-1:0] w_fill_mask;
    logic [WIDTH-1:0] w_shifted;

    // Ones in the top i_weight bit positions; these are the bits vacated by
    // the logical shift and receive the fill value.
    assign w_fill_mask = ~({WIDTH{1'b1}} >> i_weight);
    assign w_shifted   = (i_in >> i_weight) | (i_fill ? w_fill_mask : '0);
    assign o_out       = i_en ? w_shifted : i_in;

endmodule

// File: rtl/shift_right_seq.sv
// -----------------------------------------------------------------------------
// shift_right_seq
// Multi-cycle right shifter (srl / sra). One binary-weighted stage is applied
// per clock (16, 8, 4, 2, 1), giving a fixed 5-cycle latency regardless of the
// shift amount. Start-pulse / result-ready handshake matches mult/div.
// Ports:
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   ctrl_shift      start pulse; operands sampled on the edge where it is high
//                   (also aborts and restarts an in-flight operation)
//   ctrl_arith      1 = arithmetic (sign fill), 0 = logical (zero fill)
//   data_operand    value to shift
//   sh_amt          shift amount 0..31
//   data_result     shifted result, updated only on entry to DONE
//   data_resultRDY  single-cycle completion pulse (state DONE)
//   busy            high while in SHIFT
// -----------------------------------------------------------------------------
module shift_right_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_shift,
    input  logic             ctrl_arith,
    input  logic [WIDTH-1:0] data_operand,
    input  logic [4:0]       sh_amt,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_work;
    logic [4:0]       r_amt;
    logic             r_fill;
    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             w_stage_en;
    logic [WIDTH-1:0] w_stage_out;

    // Stage k uses amount bit (4-k): the largest weight is applied first.
    always_comb begin
        w_stage_en = 1'b0;
        case (r_cnt)
            3'd0:    w_stage_en = r_amt[4];
            3'd1:    w_stage_en = r_amt[3];
            3'd2:    w_stage_en = r_amt[2];
            3'd3:    w_stage_en = r_amt[1];
            3'd4:    w_stage_en = r_amt[0];
            default: w_stage_en = 1'b0;
        endcase
    end

    shr_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .i_in     (r_work),
        .i_fill   (r_fill),
        .i_en     (w_stage_en),
        .i_weight (stage_weight(r_cnt)),
        .o_out    (w_stage_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A start is accepted in every state; in SHIFT it aborts the operation
    // in flight, in DONE it chains a new one behind the completing pulse.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (ctrl_shift) w_next_state = SHIFT;
            end
            SHIFT: begin
                if (ctrl_shift)                w_next_state = SHIFT;
                else if (r_cnt == LAST_STAGE)  w_next_state = DONE;
            end
            DONE: begin
                w_next_state = ctrl_shift ? SHIFT : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_work   <= '0;
            r_amt    <= '0;
            r_fill   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (ctrl_shift) begin
            r_work   <= data_operand;
            r_amt    <= sh_amt;
            r_fill   <= ctrl_arith & data_operand[WIDTH-1];
            r_cnt    <= '0;
        end else if (r_state == SHIFT) begin
            r_work <= w_stage_out;
            r_cnt  <= r_cnt + 3'd1;
            // Result is published only when the last stage completes, so
            // aborted operations never disturb the held value.
            if (r_cnt == LAST_STAGE) begin
                r_result <= w_stage_out;
            end
        end
    end

    assign data_result    = r_result;
    assign data_resultRDY = (r_state == DONE);
    assign busy           = (r_state == SHIFT);

endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             ctrl_shift;
    logic             ctrl_arith;
    logic [WIDTH-1:0] data_operand;
    logic [4:0]       sh_amt;
    logic [WIDTH-1:0] data_result;
    logic             data_resultRDY;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    shift_right_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_shift     (ctrl_shift),
        .ctrl_arith     (ctrl_arith),
        .data_operand   (data_operand),
        .sh_amt         (sh_amt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain shift operators on the original operand.
    function automatic logic [31:0] ref_shr(input logic [31:0] op, input logic [4:0] amt,
                                            input logic arith);
        if (arith) return 32'($signed(op) >>> amt);
        return op >> amt;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues a start from the current cycle, checks busy/RDY over the
    // latency window and the result in the DONE cycle. Returns in DONE.
    task automatic run_op(input string tag, input logic [31:0] op, input logic [4:0] amt,
                          input logic arith);
        logic [31:0] exp;
        exp          = ref_shr(op, amt, arith);
        ctrl_shift   = 1'b1;
        ctrl_arith   = arith;
        data_operand = op;
        sh_amt       = amt;
        tick();
        ctrl_shift   = 1'b0;
        // operands only matter on the start edge
        ctrl_arith   = 1'($urandom);
        data_operand = $urandom;
        sh_amt       = 5'($urandom);
        for (int i = 1; i <= 5; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_rdy_early"}, 32'(data_resultRDY), 32'd0);
            tick();
        end
        check({tag, "_rdy"}, 32'(data_resultRDY), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_result"}, data_result, exp);
    endtask

    initial begin
        int          pulses;
        int          first_at;
        logic [31:0] held;
        logic [31:0] rop;
        logic [4:0]  ramt;
        logic        rar;

        reset        = 1'b1;
        ctrl_shift   = 1'b0;
        ctrl_arith   = 1'b0;
        data_operand = '0;
        sh_amt       = '0;
        tick();
        tick();
        check("rst_result", data_result, 32'd0);
        check("rst_rdy", 32'(data_resultRDY), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // Directed cases
        run_op("srl4", 32'hF000_0000, 5'd4, 1'b0);
        check("srl4_const", data_result, 32'h0F00_0000);
        tick();
        check("srl4_rdy_drop", 32'(data_resultRDY), 32'd0);
        run_op("sra31", 32'h8000_0000, 5'd31, 1'b1);
        check("sra31_const", data_result, 32'hFFFF_FFFF);
        tick();
        run_op("srl31", 32'h8000_0000, 5'd31, 1'b0);
        check("srl31_const", data_result, 32'h0000_0001);
        tick();
        run_op("sra1pos", 32'h7FFF_FFFF, 5'd1, 1'b1);
        check("sra1pos_const", data_result, 32'h3FFF_FFFF);
        tick();

        // Zero shift, then hold for 10 idle cycles
        run_op("zero", 32'h1234_5678, 5'd0, 1'b0);
        check("zero_const", data_result, 32'h1234_5678);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_rdy", 32'(data_resultRDY), 32'd0);
            check("hold_result", data_result, 32'h1234_5678);
        end

        // Abort: second start on the 3rd SHIFT cycle
        ctrl_shift = 1'b1; ctrl_arith = 1'b0; data_operand = 32'hFFFF_0000; sh_amt = 5'd8;
        tick();
        ctrl_shift = 1'b0;
        tick();
        tick();
        ctrl_shift = 1'b1; ctrl_arith = 1'b0; data_operand = 32'h0000_0100; sh_amt = 5'd4;
        tick();
        ctrl_shift = 1'b0;
        pulses   = 0;
        first_at = 0;
        for (int i = 1; i <= 12; i++) begin
            if (data_resultRDY) begin
                pulses++;
                if (first_at == 0) begin
                    first_at = i;
                    check("abort_result", data_result, 32'h0000_0010);
                end
            end else if (i < 6) begin
                check("abort_held", data_result, 32'h1234_5678);
            end
            tick();
        end
        check("abort_pulses", 32'(pulses), 32'd1);
        check("abort_latency", 32'(first_at), 32'd6);

        // Back-to-back: second start issued in the DONE cycle
        run_op("b2b_a", 32'hDEAD_BEEF, 5'd12, 1'b1);
        run_op("b2b_b", 32'h0F0F_0F0F, 5'd3, 1'b0);
        tick();

        // Reset mid-SHIFT: no pulse, outputs cleared
        ctrl_shift = 1'b1; ctrl_arith = 1'b1; data_operand = 32'h8765_4321; sh_amt = 5'd7;
        tick();
        ctrl_shift = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_result", data_result, 32'd0);
        check("rstmid_rdy", 32'(data_resultRDY), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (data_resultRDY) pulses++;
            tick();
        end
        check("rstmid_pulses", 32'(pulses), 32'd0);

        // Reset wins over a simultaneous start
        reset = 1'b1; ctrl_shift = 1'b1; data_operand = 32'hFFFF_FFFF; sh_amt = 5'd1;
        tick();
        reset = 1'b0; ctrl_shift = 1'b0;
        check("rstprio_busy", 32'(busy), 32'd0);
        tick();
        check("rstprio_busy2", 32'(busy), 32'd0);

        // Randomized operations, some chained from DONE
        for (int i = 0; i < 40; i++) begin
            rop  = $urandom;
            ramt = 5'($urandom);
            rar  = 1'($urandom);
            run_op("rand", rop, ramt, rar);
            if ($urandom_range(0, 1) == 0) tick();
            held = ref_shr(rop, ramt, rar);
            check("rand_keep", data_result, held);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
